bit_serializer: RTL



---
 rtl/bit_serializer_pkg.sv | 13 +
 rtl/bit_serializer_strobe_gen.sv | 38 +++
 rtl/bit_serializer.sv | 87 ++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared configuration for the bit serializer: state encoding and default sizing.
package bit_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_W   = 8;
  localparam int unsigned DEFAULT_DIV = 4;

endpackage

// File: rtl/bit_serializer_strobe_gen.sv
// Mod-DIV bit-period divider; tick marks the last cycle of each period while running.
module strobe_gen
  import bit_serializer_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = run && (cnt_q == CNT_MAX);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter, MSB first, with one en strobe per bit period for the
// downstream pattern detector.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int unsigned W   = DEFAULT_W,
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] data,
  output logic         busy,
  output logic         en,
  output logic         a,
  output logic         done
);

  localparam int unsigned BCW = $clog2(W + 1);

  state_e         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [BCW-1:0] bitcnt_q, bitcnt_d;
  logic           accept;
  logic           tick;

  strobe_gen #(
    .DIV (DIV)
  ) u_strobe_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .run   (busy),
    .tick  (tick)
  );

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    accept   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          shreg_d  = data;
          bitcnt_d = BCW'(W);
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick) begin
          shreg_d  = shreg_q << 1;
          bitcnt_d = bitcnt_q - 1'b1;
          if (bitcnt_q == BCW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
    end
  end

  // Outputs depend on registered state only, so start/data never reach them combinationally.
  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign en   = tick;
  assign a    = busy & shreg_q[W-1];

endmodule
